// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one SLICE-wide slice of the result per BUSY cycle,
// with a registered zero flag and a running popcount of the result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | building y one slice per cycle, LSB slice first
// DONE  | result held with out_valid high until out_ready
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    localparam int PW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [PW-1:0]    pop
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IW     = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
    logic [2:0]         op_q, op_d;
    logic [PW-1:0]      pop_q, pop_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   res_full;
    logic [SLICE-1:0]   slice_val;
    logic [PW-1:0]      slice_pop;
    logic [IW-1:0]      idx;
    logic               last_slice;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            y_q     <= '0;
            pop_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            y_q     <= y_d;
            pop_q   <= pop_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        case (op_q)
            3'b000:  res_full = a_q & b_q;
            3'b001:  res_full = a_q | b_q;
            3'b010:  res_full = a_q ^ b_q;
            3'b011:  res_full = ~(a_q & b_q);
            3'b100:  res_full = ~(a_q | b_q);
            3'b101:  res_full = ~(a_q ^ b_q);
            3'b110:  res_full = a_q & ~b_q;
            default: res_full = a_q;
        endcase
        idx        = IW'(cnt_q) * IW'(SLICE);
        slice_val  = res_full[idx +: SLICE];
        last_slice = (cnt_q == CW'(NSLICE - 1));
        slice_pop  = '0;
        for (int i = 0; i < SLICE; i++) begin
            slice_pop = slice_pop + PW'(slice_val[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_BUSY;
            S_BUSY:  if (last_slice) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        y_d    = y_q;
        pop_d  = pop_q;
        zero_d = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    op_d   = op;
                    y_d    = '0;
                    pop_d  = '0;
                    cnt_d  = '0;
                    zero_d = 1'b0;
                end
            end
            S_BUSY: begin
                y_d[idx +: SLICE] = slice_val;
                pop_d = pop_q + slice_pop;
                cnt_d = last_slice ? '0 : cnt_q + CW'(1);
                // zero is captured once the final slice lands
                if (last_slice) zero_d = (y_d == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
    end

    assign y    = y_q;
    assign zero = zero_q;
    assign pop  = pop_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: three instances (SLICE=8, 32, 1) share stimulus
// so results and latencies can be checked side by side.
module tb_logic_unit_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic [2:0]  op;

    logic [31:0] y_o  [3];
    logic [5:0]  pop_o[3];
    logic        zero_o[3];
    logic        ov[3];
    logic        ir[3];

    int total = 0;
    int bad   = 0;
    int lat_obs[3];
    int lat_exp[3] = '{5, 2, 33};

    logic [31:0] sw_y  [8] = '{32'h0A0A5050, 32'hAFAFF5F5, 32'hA5A5A5A5, 32'hF5F5AFAF,
                               32'h50500A0A, 32'h5A5A5A5A, 32'hA0A00505, 32'hAAAA5555};
    int          sw_pop[8] = '{8, 24, 16, 24, 8, 16, 8, 16};

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .y(y_o[0]), .zero(zero_o[0]), .pop(pop_o[0]));

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .y(y_o[1]), .zero(zero_o[1]), .pop(pop_o[1]));

    logic_unit_seq #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .y(y_o[2]), .zero(zero_o[2]), .pop(pop_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepts one operation on all instances and waits until every one shows out_valid.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [2:0] top);
        int n;
        n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL start_timeout in_ready got=%b%b%b want=111", ir[0], ir[1], ir[2]);
        end
        a = ta; b = tbv; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tbv; op = top + 3'd1;
        for (int i = 0; i < 3; i++) lat_obs[i] = 0;
        n = 1;
        while (n <= 40) begin
            for (int i = 0; i < 3; i++) if (ov[i] && lat_obs[i] == 0) lat_obs[i] = n;
            if (lat_obs[0] != 0 && lat_obs[1] != 0 && lat_obs[2] != 0) break;
            @(posedge clk); #1; n++;
        end
        total++;
        if (lat_obs[0] == 0 || lat_obs[1] == 0 || lat_obs[2] == 0) begin
            bad++;
            $display("FAIL done_timeout out_valid got=%b%b%b want=111", ov[0], ov[1], ov[2]);
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || y_o[i] !== 32'h0 || pop_o[i] !== 6'd0 || zero_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state inst%0d got ir=%b ov=%b y=%h pop=%0d zero=%b want 0 0 0 0 0",
                         i, ir[i], ov[i], y_o[i], pop_o[i], zero_o[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ir[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_release_ready inst%0d got=%b want=1", i, ir[i]);
            end
        end
    endtask

    task automatic test_and_basic();
        start_op(32'hF0F01234, 32'hFF0000FF, 3'b000);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (y_o[i] !== 32'hF0000034 || pop_o[i] !== 6'd7 || zero_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL and_basic inst%0d got y=%h pop=%0d zero=%b want y=f0000034 pop=7 zero=0",
                         i, y_o[i], pop_o[i], zero_o[i]);
            end
            total++;
            if (lat_obs[i] != lat_exp[i]) begin
                bad++;
                $display("FAIL latency inst%0d got=%0d want=%0d", i, lat_obs[i], lat_exp[i]);
            end
        end
        release_op();
    endtask

    task automatic test_op_sweep();
        for (int k = 0; k < 8; k++) begin
            start_op(32'hAAAA5555, 32'h0F0FF0F0, 3'(k));
            for (int i = 0; i < 3; i++) begin
                total++;
                if (y_o[i] !== sw_y[k] || pop_o[i] !== 6'(sw_pop[k]) || zero_o[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL op_sweep op=%0d inst%0d got y=%h pop=%0d zero=%b want y=%h pop=%0d zero=0",
                             k, i, y_o[i], pop_o[i], zero_o[i], sw_y[k], sw_pop[k]);
                end
            end
            release_op();
        end
    endtask

    task automatic test_equal_operands();
        start_op(32'h12345678, 32'h12345678, 3'b010);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (y_o[i] !== 32'h0 || pop_o[i] !== 6'd0 || zero_o[i] !== 1'b1) begin
                bad++;
                $display("FAIL xor_zero inst%0d got y=%h pop=%0d zero=%b want y=0 pop=0 zero=1",
                         i, y_o[i], pop_o[i], zero_o[i]);
            end
        end
        release_op();
        start_op(32'h12345678, 32'h12345678, 3'b101);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (y_o[i] !== 32'hFFFFFFFF || pop_o[i] !== 6'd32 || zero_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL xnor_full inst%0d got y=%h pop=%0d zero=%b want y=ffffffff pop=32 zero=0",
                         i, y_o[i], pop_o[i], zero_o[i]);
            end
        end
        release_op();
    endtask

    task automatic test_backpressure();
        start_op(32'hF0F01234, 32'hFF0000FF, 3'b000);
        for (int k = 0; k < 10; k++) begin
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); in_valid = (k % 2 == 1);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (y_o[i] !== 32'hF0000034 || pop_o[i] !== 6'd7 || ov[i] !== 1'b1 || ir[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL hold cyc%0d inst%0d got y=%h pop=%0d ov=%b ir=%b want y=f0000034 pop=7 ov=1 ir=0",
                             k, i, y_o[i], pop_o[i], ov[i], ir[i]);
                end
            end
        end
        in_valid = 1'b0;
        release_op();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
                bad++;
                $display("FAIL hold_release inst%0d got ir=%b ov=%b want ir=1 ov=0", i, ir[i], ov[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen[3];
        a = 32'hF0F01234; b = 32'hFF0000FF; op = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ov[i] !== 1'b0 || y_o[i] !== 32'h0 || pop_o[i] !== 6'd0 || ir[i] !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset inst%0d got ov=%b y=%h pop=%0d ir=%b want 0 0 0 0",
                         i, ov[i], y_o[i], pop_o[i], ir[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++) if (ov[i]) seen[i] = 1'b1;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] !== 1'b0 || ir[i] !== 1'b1) begin
                bad++;
                $display("FAIL mid_reset_no_result inst%0d got seen_valid=%b ir=%b want 0 1", i, seen[i], ir[i]);
            end
        end
        start_op(32'hAAAA5555, 32'h0F0FF0F0, 3'b110);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (y_o[i] !== 32'hA0A00505 || pop_o[i] !== 6'd8 || lat_obs[i] != lat_exp[i]) begin
                bad++;
                $display("FAIL after_reset inst%0d got y=%h pop=%0d lat=%0d want y=a0a00505 pop=8 lat=%0d",
                         i, y_o[i], pop_o[i], lat_obs[i], lat_exp[i]);
            end
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_and_basic();
        test_op_sweep();
        test_equal_operands();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
